// File: rtl/store_align.sv
// -----------------------------------------------------------------------------
// store_align
//
// Store-path data formatter for the RV32 core. A store request (byte address,
// 32-bit register data, access size) is narrowed to its byte/half/word payload,
// shifted into byte-lane position and presented to the data-memory write port
// as one or two word-aligned beats with byte enables. A store whose bytes run
// past the end of the addressed word is split into a second beat at the next
// word address (wrapping modulo 2^ADDR_WIDTH).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   store request present
//   req_ready  out  request accepted this cycle if valid (high only in IDLE)
//   req_addr   in   byte address of the store
//   req_data   in   store data, low 1/2/4 bytes used according to size
//   req_size   in   00 byte, 01 half, 10 word, 11 illegal
//   bus_valid  out  write beat valid (BEAT0/BEAT1)
//   bus_ready  in   memory accepts the current beat
//   bus_addr   out  word-aligned beat address
//   bus_wdata  out  lane-positioned write data
//   bus_be     out  byte enables, bit i covers bus_wdata[8i+7:8i]
//   done       out  one-cycle pulse after the last beat is accepted
//   err        out  one-cycle pulse after an illegal-size request is accepted
//   busy       out  a store is in flight
// -----------------------------------------------------------------------------
module store_align #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Byte offset of one word, used to step to the second beat's address.
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};

  // Keep only the bytes that the access size covers; upper bytes become 0.
  function automatic logic [31:0] mask_data(input logic [31:0] data,
                                            input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = {24'h00_0000, data[7:0]};
      SIZE_HALF: res = {16'h0000, data[15:0]};
      SIZE_WORD: res = data;
      default:   res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Unshifted byte-enable pattern for the access size.
  function automatic logic [3:0] mask_be(input logic [1:0] size);
    logic [3:0] res;
    case (size)
      SIZE_BYTE: res = 4'b0001;
      SIZE_HALF: res = 4'b0011;
      SIZE_WORD: res = 4'b1111;
      default:   res = 4'b0000;
    endcase
    return res;
  endfunction

  state_t                  state_r;
  state_t                  state_nx;

  // Second-beat payload, prepared at accept time so the switch from beat0 to
  // beat1 is a plain register copy.
  logic [ADDR_WIDTH-1:0]   hi_addr_r;
  logic [31:0]             hi_data_r;
  logic [3:0]              hi_be_r;

  logic                    done_r;
  logic                    err_r;
  logic [ADDR_WIDTH-1:0]   bus_addr_r;
  logic [31:0]             bus_wdata_r;
  logic [3:0]              bus_be_r;

  logic                    accept_s;
  logic                    legal_s;
  logic [31:0]             mdata_s;
  logic [3:0]              mbe_s;
  logic [63:0]             lane_s;
  logic [7:0]              be8_s;
  logic [ADDR_WIDTH-1:0]   base_s;
  logic                    load_lo_s;
  logic                    load_hi_s;
  logic                    done_nx;
  logic                    err_nx;

  assign accept_s = req_valid && (state_r == IDLE);
  assign legal_s  = (req_size != SIZE_ILLEGAL);

  // Position request data and enables into a two-word lane window.
  always_comb begin
    mdata_s = mask_data(req_data, req_size);
    mbe_s   = mask_be(req_size);
    lane_s  = {32'h0000_0000, mdata_s} << {req_addr[1:0], 3'b000};
    be8_s   = {4'b0000, mbe_s} << req_addr[1:0];
    base_s  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state and datapath control decode.
  always_comb begin
    state_nx  = state_r;
    load_lo_s = 1'b0;
    load_hi_s = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (legal_s) begin
            state_nx  = BEAT0;
            load_lo_s = 1'b1;
          end else begin
            // Illegal size: report and stay idle, no bus traffic.
            state_nx  = IDLE;
            err_nx    = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (hi_be_r != 4'b0000) begin
            state_nx  = BEAT1;
            load_hi_s = 1'b1;
          end else begin
            state_nx  = IDLE;
            done_nx   = 1'b1;
          end
        end else begin
          state_nx = BEAT0;
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = BEAT1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Beat registers and status pulses; beat fields only change on a load, so
  // they stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr_r  <= '0;
      bus_wdata_r <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      hi_addr_r   <= '0;
      hi_data_r   <= 32'h0000_0000;
      hi_be_r     <= 4'b0000;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= done_nx;
      err_r  <= err_nx;
      if (load_lo_s) begin
        bus_addr_r  <= base_s;
        bus_wdata_r <= lane_s[31:0];
        bus_be_r    <= be8_s[3:0];
        hi_addr_r   <= base_s + WORD_STEP;
        hi_data_r   <= lane_s[63:32];
        hi_be_r     <= be8_s[7:4];
      end else if (load_hi_s) begin
        bus_addr_r  <= hi_addr_r;
        bus_wdata_r <= hi_data_r;
        bus_be_r    <= hi_be_r;
      end else begin
        bus_addr_r  <= bus_addr_r;
        bus_wdata_r <= bus_wdata_r;
        bus_be_r    <= bus_be_r;
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign bus_valid = (state_r != IDLE);
  assign busy      = (state_r != IDLE);
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_be    = bus_be_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_store_align.sv
// -----------------------------------------------------------------------------
// tb_store_align: table of store requests with expected beats; expected beats
// are queued when a request is driven and compared by a bus monitor at each
// accepted beat. Hand-written sequences cover back-to-back accept and reset in
// the middle of a split store.
// -----------------------------------------------------------------------------
module tb_store_align;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        done;
  logic        err;
  logic        busy;

  store_align #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          stall;
    int          beats;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } beat_t;

  beat_t sb_q[$];
  vec_t  vecs[11];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bus monitor: scoreboard compare on each handshake, stability under stall.
  logic        hold_v = 1'b0;
  logic [31:0] hold_a;
  logic [31:0] hold_d;
  logic [3:0]  hold_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("done_err_excl", {63'd0, done & err}, 64'd0);
      if (bus_valid) begin
        chk("rdy_low_busy", {63'd0, req_ready}, 64'd0);
        chk("be_nonzero", {63'd0, bus_be == 4'b0000}, 64'd0);
        if (hold_v) begin
          chk("hold_addr", bus_addr, hold_a);
          chk("hold_wdata", bus_wdata, hold_d);
          chk("hold_be", bus_be, hold_b);
        end
        if (bus_ready) begin
          hold_v = 1'b0;
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_beat", sb_q.size(), 1);
          end else begin
            beat_t e;
            e = sb_q.pop_front();
            chk("beat_addr", bus_addr, e.a);
            chk("beat_wdata", bus_wdata, e.d);
            chk("beat_be", bus_be, e.b);
          end
        end else begin
          hold_v = 1'b1;
          hold_a = bus_addr;
          hold_d = bus_wdata;
          hold_b = bus_be;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int sc;
    int lat;
    bit got;
    if (v.beats >= 1) sb_q.push_back({v.a0, v.d0, v.b0});
    if (v.beats == 2) sb_q.push_back({v.a1, v.d1, v.b1});
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.beats == 0) begin
      @(negedge clk);
      chk("err_pulse", {63'd0, err}, 64'd1);
      chk("err_no_valid", {63'd0, bus_valid}, 64'd0);
      @(negedge clk);
      chk("err_once", {63'd0, err}, 64'd0);
      chk("err_no_valid2", {63'd0, bus_valid}, 64'd0);
    end else begin
      sc  = 0;
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
        if (bus_valid && sc < v.stall) begin
          bus_ready = 1'b0;
          sc++;
        end else begin
          bus_ready = 1'b1;
          sc = 0;
        end
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          lat = c;
        end else begin
          @(posedge clk); #1;
        end
      end
      chk("done_seen", {63'd0, got}, 64'd1);
      chk("latency", lat, v.beats + 1 + v.beats * v.stall);
      @(negedge clk);
      chk("done_once", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1000, 32'hAABB_CCDD, 2'b10, 0, 1, 32'h0000_1000, 32'hAABB_CCDD, 4'hF, 32'h0, 32'h0, 4'h0};
    vecs[1]  = '{32'h0000_3002, 32'hFFFF_FF5A, 2'b00, 0, 1, 32'h0000_3000, 32'h005A_0000, 4'h4, 32'h0, 32'h0, 4'h0};
    vecs[2]  = '{32'h0000_2003, 32'h1234_5678, 2'b01, 0, 2, 32'h0000_2000, 32'h7800_0000, 4'h8, 32'h0000_2004, 32'h0000_0056, 4'h1};
    vecs[3]  = '{32'h0000_1001, 32'hAABB_CCDD, 2'b10, 3, 2, 32'h0000_1000, 32'hBBCC_DD00, 4'hE, 32'h0000_1004, 32'h0000_00AA, 4'h1};
    vecs[4]  = '{32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 0, 2, 32'hFFFF_FFFC, 32'h3344_0000, 4'hC, 32'h0000_0000, 32'h0000_1122, 4'h3};
    vecs[5]  = '{32'h0000_1002, 32'hDEAD_BEEF, 2'b01, 0, 1, 32'h0000_1000, 32'hBEEF_0000, 4'hC, 32'h0, 32'h0, 4'h0};
    vecs[6]  = '{32'h0000_0003, 32'h0000_00A5, 2'b00, 0, 1, 32'h0000_0000, 32'hA500_0000, 4'h8, 32'h0, 32'h0, 4'h0};
    vecs[7]  = '{32'h0000_4001, 32'hCAFE_1234, 2'b01, 1, 1, 32'h0000_4000, 32'h0012_3400, 4'h6, 32'h0, 32'h0, 4'h0};
    vecs[8]  = '{32'h0000_5003, 32'h0102_0304, 2'b10, 0, 2, 32'h0000_5000, 32'h0400_0000, 4'h8, 32'h0000_5004, 32'h0001_0203, 4'h7};
    vecs[9]  = '{32'h0000_1234, 32'h5555_5555, 2'b11, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[10] = '{32'h0000_6001, 32'h0000_0077, 2'b00, 2, 1, 32'h0000_6000, 32'h0000_7700, 4'h2, 32'h0, 32'h0, 4'h0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_size  = 2'b00;
    bus_ready = 1'b0;
    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_bus_be", bus_be, 64'd0);
    chk("rst_done_err_busy", {61'd0, done, err, busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Back-to-back: second request accepted in the done cycle of the first.
    sb_q.push_back({32'h0000_0100, 32'h0000_0001, 4'hF});
    sb_q.push_back({32'h0000_0104, 32'h0000_0002, 4'hF});
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_data = 32'h0000_0001; req_size = 2'b10;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h0000_0104; req_data = 32'h0000_0002;
    @(negedge clk);
    chk("b2b_rdy_low", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_done_a", {63'd0, done}, 64'd1);
    chk("b2b_rdy_done", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_b", {63'd0, bus_valid}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_done_b", {63'd0, done}, 64'd1);

    // Reset during beat1 backpressure of a split store.
    sb_q.push_back({32'h0000_1000, 32'hBBCC_DD00, 4'hE});
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_1001; req_data = 32'hAABB_CCDD; req_size = 2'b10;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_beat1_be", bus_be, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {63'd0, bus_valid}, 64'd0);
    chk("rstmid_addr", bus_addr, 64'd0);
    chk("rstmid_wdata", bus_wdata, 64'd0);
    chk("rstmid_be", bus_be, 64'd0);
    chk("rstmid_rdy_busy", {62'd0, req_ready, busy}, 64'h2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstmid_no_done", {62'd0, done, bus_valid}, 64'd0);
    end

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_align.md
# store_align

Store-path counterpart of the load sign/zero extender in the RV32 core. It takes a store request from the execute stage (byte address, 32-bit register data, access size) and narrows and packs the data into word-aligned data-bus writes with byte enables. Stores that cross a 32-bit word boundary are split into two bus beats. It sits between the execute/memory stage and the data-memory write port.

## Interface
- `ADDR_WIDTH`, default 32: width of the request and bus addresses.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  1: store request present.
- `req_ready`  out  1: block can accept a request. High only in IDLE.
- `req_addr`  in  ADDR_WIDTH: byte address.
- `req_data`  in  32: store data. Only the low 1/2/4 bytes are used, per size.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `bus_valid`  out  1: write beat valid.
- `bus_ready`  in  1: memory accepts the beat.
- `bus_addr`  out  ADDR_WIDTH: word-aligned beat address. Bits [1:0] are always 0.
- `bus_wdata`  out  32: lane-positioned write data.
- `bus_be`  out  4: byte enables. Bit i enables bytes [8i+7:8i].
- `done`  out  1: one-cycle pulse after the last beat of a store is accepted.
- `err`  out  1: one-cycle pulse for an illegal size. No bus traffic is generated.
- `busy`  out  1: state is not IDLE.

## Operation
- Accept when `req_valid && req_ready`. Capture addr, data, size in registers.
- Define `off = req_addr[1:0]`.
- Data mask:
  - byte: `req_data[7:0]`
  - half: `req_data[15:0]`
  - word: all 32 bits
  - Unused upper bits are forced to 0.
- Byte mask: 0001 (byte), 0011 (half), 1111 (word).
- Form a 64-bit lane: `{32'b0, masked_data} << (8*off)`.
- Form an 8-bit enable: `mask << off`.
- Beat0:
  - `bus_addr = {addr[ADDR_WIDTH-1:2], 2'b00}`
  - `bus_wdata = lane[31:0]`
  - `bus_be = be8[3:0]`
- Beat1 exists only if `be8[7:4] != 0`:
  - `bus_addr = beat0 addr + 4`, modulo 2^ADDR_WIDTH (wraps to 0)
  - `bus_wdata = lane[63:32]`
  - `bus_be = be8[7:4]`
- FSM states IDLE, BEAT0, BEAT1:
  - IDLE → BEAT0 on accept with a legal size.
  - IDLE → IDLE on accept with size 11. `err` pulses the next cycle.
  - BEAT0 → BEAT1 on `bus_ready` when a second beat is needed.
  - BEAT0 → IDLE on `bus_ready` otherwise.
  - BEAT1 → IDLE on `bus_ready`.
- `bus_valid` is 1 exactly in BEAT0 and BEAT1.
- While `bus_valid` is high and `bus_ready` is low, `bus_addr`, `bus_wdata` and `bus_be` hold stable.
- `bus_be` is never 0 while `bus_valid` is high.

## Timing
- Reset values: state IDLE; `req_ready=1`; `bus_valid=0`; `bus_addr=0`; `bus_wdata=0`; `bus_be=0`; `done=0`; `err=0`; `busy=0`.
- All outputs are registered, or decoded only from the state register.
- Accept at edge N: `bus_valid` is high in cycle N+1.
- Beat handshake at edge M:
  - Single-beat store: `done`=1 in cycle M+1.
  - Two-beat store: beat1 is presented in cycle M+1.
- Minimum latency, accept to `done`: 2 cycles (single beat), 3 cycles (split), with `bus_ready` held high.
- In the `done` cycle the state is IDLE and `req_ready`=1, so back-to-back accept is allowed. Sustained throughput is one single-beat store every 2 cycles.
- `done` and `err` are never high in the same cycle.
- Reset asserted mid-store clears everything immediately. Any unaccepted beat is dropped and no `done` is produced.

## Test plan
- Word at 0x1000, data 0xAABBCCDD, `bus_ready`=1 → one beat: addr 0x1000, wdata 0xAABBCCDD, be 1111. `done` 2 cycles after accept.
- Byte at 0x3002, data 0xFFFFFF5A → one beat: addr 0x3000, wdata 0x005A0000, be 0100.
- Half at 0x2003, data 0x12345678 → beat0: addr 0x2000, wdata 0x78000000, be 1000. Beat1: addr 0x2004, wdata 0x00000056, be 0001.
- Word at 0x1001, data 0xAABBCCDD, `bus_ready` low for 3 cycles on each beat → beat0: 0x1000/0xBBCCDD00/1110, held stable. Beat1: 0x1004/0x000000AA/0001. Single `done` pulse. `req_ready`=0 throughout.
- Word at 0xFFFFFFFE, data 0x11223344 → beat0: 0xFFFFFFFC/0x33440000/1100. Beat1: 0x00000000/0x00001122/0011.
- Size 11 at any address → `err` pulses once, `bus_valid` stays 0. Separately, reset asserted during beat1 backpressure → outputs return to reset values at once and no `done` appears.
